// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like req/addr_ok/data_ok bus between instruction fetch and data access.
// Data has fixed priority; inst wins after STARVE_LIMIT consecutive losses. One transaction in flight.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_req,
    input  logic [1:0]          inst_size,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       owner;        // 0 = inst, 1 = data
    logic [2:0] starve_cnt;
    logic       any_req;
    logic       grant_data;

    assign any_req    = inst_req | data_req;
    assign grant_data = data_req && !(inst_req && (starve_cnt == STARVE_MAX));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req)     state_next = ADDR;
            ADDR:    if (bus_addr_ok) state_next = DATA;
            DATA:    if (bus_data_ok) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= 3'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                owner <= grant_data;
                if (!grant_data)
                    starve_cnt <= 3'd0;
                else if (inst_req && starve_cnt != STARVE_MAX)
                    starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    // Payload follows the owner; a fetch never drives write data or strobes.
    assign bus_req   = (state == ADDR);
    assign bus_wr    = owner & data_wr;
    assign bus_size  = owner ? data_size  : inst_size;
    assign bus_wstrb = owner ? data_wstrb : '0;
    assign bus_addr  = owner ? data_addr  : inst_addr;
    assign bus_wdata = owner ? data_wdata : '0;

    assign inst_addr_ok = (state == ADDR) && !owner && bus_addr_ok;
    assign data_addr_ok = (state == ADDR) &&  owner && bus_addr_ok;

    // Responses outside DATA are stale (e.g. left over across a reset) and are dropped.
    assign inst_data_ok = (state == DATA) && !owner && bus_data_ok;
    assign data_data_ok = (state == DATA) &&  owner && bus_data_ok;

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: one task per scenario with inline comparisons.
// A small slave-side task drives bus handshakes and records what the arbiter presented.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        iaok;
        logic        daok;
        logic        idok;
        logic        ddok;
        logic [31:0] irdata;
        logic [31:0] drdata;
        int          unstable;
    } obs_t;

    mem_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_wstrb    (bus_wstrb),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in ADDR: stalls addr_ok for addr_wait cycles, then data_ok after data_wait DATA cycles.
    // The owner drops its request after addr_ok; inst re-requests with next_inst_req.
    task automatic serve(input int addr_wait, input int data_wait, input logic [31:0] rdata,
                         input logic next_inst_req, output obs_t o);
        o.unstable = 0;
        #1;
        o.addr = bus_addr;
        o.req  = bus_req;
        for (int i = 0; i < addr_wait; i++) begin
            bus_addr_ok = 1'b0;
            #1;
            if (bus_req !== 1'b1 || bus_addr !== o.addr || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0)
                o.unstable++;
            tick();
        end
        bus_addr_ok = 1'b1;
        #1;
        o.req   = o.req & bus_req;
        o.wr    = bus_wr;
        o.size  = bus_size;
        o.wstrb = bus_wstrb;
        if (bus_addr !== o.addr) o.unstable++;
        o.wdata = bus_wdata;
        o.iaok  = inst_addr_ok;
        o.daok  = data_addr_ok;
        tick();
        bus_addr_ok = 1'b0;
        if (o.daok === 1'b1) data_req = 1'b0;
        if (o.iaok === 1'b1) inst_req = next_inst_req;
        for (int i = 0; i < data_wait; i++) begin
            #1;
            if (bus_req !== 1'b0 || inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) o.unstable++;
            tick();
        end
        bus_data_ok = 1'b1;
        bus_rdata   = rdata;
        #1;
        if (bus_req !== 1'b0) o.unstable++;
        o.idok   = inst_data_ok;
        o.ddok   = data_data_ok;
        o.irdata = inst_rdata;
        o.drdata = data_rdata;
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        tests++; if (dut.state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", dut.state); end
        tests++; if (dut.owner !== 1'b0) begin fails++; $display("FAIL reset_owner: got %b want 0", dut.owner); end
        tests++; if (dut.starve_cnt !== 3'd0) begin fails++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt); end
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        #1;
        tests++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
            fails++; $display("FAIL idle_stale_handshake: got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        tests++; if (dut.state !== 2'd0) begin fails++; $display("FAIL idle_hold: got state %0d want 0", dut.state); end
    endtask

    task automatic test_inst_read();
        obs_t o;
        data_wr    = 1'b1;
        data_wstrb = 4'hf;
        data_wdata = 32'ha5a5a5a5;
        inst_req   = 1'b1;
        inst_size  = 2'd2;
        inst_addr  = 32'h1c000000;
        #1;
        tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL inst_grant_latency: bus_req got %b want 0", bus_req); end
        tick();
        serve(0, 1, 32'h02800c0c, 1'b0, o);
        tests++; if (o.req !== 1'b1) begin fails++; $display("FAIL inst_bus_req: got %b want 1", o.req); end
        tests++; if (o.addr !== 32'h1c000000) begin fails++; $display("FAIL inst_bus_addr: got %h want 1c000000", o.addr); end
        tests++; if ({o.wr, o.wstrb} !== 5'b0) begin fails++; $display("FAIL inst_wr_wstrb: got %b want 00000", {o.wr, o.wstrb}); end
        tests++; if (o.wdata !== 32'h0) begin fails++; $display("FAIL inst_wdata: got %h want 00000000", o.wdata); end
        tests++; if (o.size !== 2'd2) begin fails++; $display("FAIL inst_size: got %0d want 2", o.size); end
        tests++; if ({o.iaok, o.daok} !== 2'b10) begin fails++; $display("FAIL inst_addr_ok_route: got %b want 10", {o.iaok, o.daok}); end
        tests++; if ({o.idok, o.ddok} !== 2'b10) begin fails++; $display("FAIL inst_data_ok_route: got %b want 10", {o.idok, o.ddok}); end
        tests++; if (o.irdata !== 32'h02800c0c) begin fails++; $display("FAIL inst_rdata: got %h want 02800c0c", o.irdata); end
        tests++; if (o.unstable !== 0) begin fails++; $display("FAIL inst_handshake: got %0d glitches want 0", o.unstable); end
        tests++; if (inst_data_ok !== 1'b0) begin fails++; $display("FAIL inst_data_ok_single: got %b want 0", inst_data_ok); end
    endtask

    task automatic test_simultaneous();
        obs_t o;
        inst_req   = 1'b1;
        inst_addr  = 32'h1c000004;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = 32'h1c008000;
        data_wstrb = 4'hf;
        data_wdata = 32'hdeadbeef;
        tick();
        serve(0, 0, 32'h0, 1'b0, o);
        tests++; if ({o.iaok, o.daok} !== 2'b01) begin fails++; $display("FAIL sim_data_first: got %b want 01", {o.iaok, o.daok}); end
        tests++; if (o.wr !== 1'b1 || o.wdata !== 32'hdeadbeef) begin fails++; $display("FAIL sim_store_payload: got wr=%b wdata=%h want wr=1 wdata=deadbeef", o.wr, o.wdata); end
        tests++; if (o.addr !== 32'h1c008000 || o.wstrb !== 4'hf) begin fails++; $display("FAIL sim_store_addr: got %h/%h want 1c008000/f", o.addr, o.wstrb); end
        tests++; if ({o.idok, o.ddok} !== 2'b01) begin fails++; $display("FAIL sim_store_done: got %b want 01", {o.idok, o.ddok}); end
        tests++; if (dut.starve_cnt !== 3'd1) begin fails++; $display("FAIL sim_starve_inc: got %0d want 1", dut.starve_cnt); end
        tick();
        serve(0, 0, 32'h11111111, 1'b0, o);
        tests++; if (o.iaok !== 1'b1 || o.addr !== 32'h1c000004) begin fails++; $display("FAIL sim_inst_next: got aok=%b addr=%h want 1/1c000004", o.iaok, o.addr); end
        tests++; if (o.irdata !== 32'h11111111 || o.idok !== 1'b1) begin fails++; $display("FAIL sim_inst_data: got ok=%b rdata=%h want 1/11111111", o.idok, o.irdata); end
        tests++; if (dut.starve_cnt !== 3'd0) begin fails++; $display("FAIL sim_starve_end: got %0d want 0", dut.starve_cnt); end
    endtask

    task automatic test_starvation();
        obs_t o;
        inst_req  = 1'b1;
        inst_addr = 32'h1c000100;
        data_wr   = 1'b0;
        data_addr = 32'h1c008010;
        for (int r = 0; r < 2; r++) begin
            for (int g = 0; g < 5; g++) begin
                data_req = 1'b1;
                tick();
                serve(0, 0, 32'h0, 1'b1, o);
                tests++; if ({o.iaok, o.daok} !== ((g < 4) ? 2'b01 : 2'b10)) begin
                    fails++; $display("FAIL starve_winner r%0d g%0d: got %b want %b", r, g, {o.iaok, o.daok}, (g < 4) ? 2'b01 : 2'b10);
                end
                tests++; if (dut.starve_cnt !== ((g < 4) ? 3'(g + 1) : 3'd0)) begin
                    fails++; $display("FAIL starve_cnt r%0d g%0d: got %0d want %0d", r, g, dut.starve_cnt, (g < 4) ? g + 1 : 0);
                end
            end
        end
        inst_req = 1'b0;
        data_req = 1'b0;
    endtask

    task automatic test_backpressure();
        obs_t o;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h1c008020;
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h1c000200;
        serve(5, 1, 32'hcafef00d, 1'b0, o);
        tests++; if (o.unstable !== 0) begin fails++; $display("FAIL bp_stable: got %0d glitches want 0", o.unstable); end
        tests++; if (o.addr !== 32'h1c008020 || o.req !== 1'b1) begin fails++; $display("FAIL bp_addr: got %h req=%b want 1c008020 req=1", o.addr, o.req); end
        tests++; if ({o.iaok, o.daok, o.idok, o.ddok} !== 4'b0101) begin fails++; $display("FAIL bp_route: got %b want 0101", {o.iaok, o.daok, o.idok, o.ddok}); end
        tests++; if (o.drdata !== 32'hcafef00d) begin fails++; $display("FAIL bp_rdata: got %h want cafef00d", o.drdata); end
        tests++; if (dut.starve_cnt !== 3'd0) begin fails++; $display("FAIL bp_starve_hold: got %0d want 0", dut.starve_cnt); end
        tick();
        serve(0, 0, 32'h0, 1'b0, o);
        tests++; if (o.iaok !== 1'b1 || o.addr !== 32'h1c000200) begin fails++; $display("FAIL bp_late_inst: got aok=%b addr=%h want 1/1c000200", o.iaok, o.addr); end
    endtask

    task automatic test_reset_mid_op();
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h1c008040;
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        data_req    = 1'b0;
        tests++; if (dut.state !== 2'd2) begin fails++; $display("FAIL rst_reach_data: got state %0d want 2", dut.state); end
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hbad0bad0;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin fails++; $display("FAIL rst_drop_resp: got %b want 00", {inst_data_ok, data_data_ok}); end
        tests++; if (bus_req !== 1'b0 || dut.state !== 2'd0) begin fails++; $display("FAIL rst_idle: got req=%b state=%0d want 0/0", bus_req, dut.state); end
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        tests++; if (bus_req !== 1'b0 || dut.state !== 2'd0) begin fails++; $display("FAIL rst_after: got req=%b state=%0d want 0/0", bus_req, dut.state); end
    endtask

    task automatic test_store_routing();
        obs_t o;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd1;
        data_addr  = 32'h1c008030;
        data_wstrb = 4'h3;
        data_wdata = 32'h0badf00d;
        tick();
        serve(0, 0, 32'h12345678, 1'b0, o);
        tests++; if ({o.idok, o.ddok} !== 2'b01) begin fails++; $display("FAIL store_route: got %b want 01", {o.idok, o.ddok}); end
        tests++; if (o.drdata !== 32'h12345678) begin fails++; $display("FAIL store_rdata: got %h want 12345678", o.drdata); end
        tests++; if (o.wstrb !== 4'h3 || o.size !== 2'd1) begin fails++; $display("FAIL store_strb_size: got %h/%0d want 3/1", o.wstrb, o.size); end
        inst_req    = 1'b1;
        inst_addr   = 32'h1c000300;
        bus_addr_ok = 1'b1;
        #1;
        tests++; if (inst_addr_ok !== 1'b0) begin fails++; $display("FAIL store_idle_aok: got %b want 0", inst_addr_ok); end
        bus_addr_ok = 1'b0;
        tick();
        serve(0, 0, 32'h0, 1'b0, o);
        tests++; if ({o.iaok, o.daok} !== 2'b10) begin fails++; $display("FAIL store_next_inst: got %b want 10", {o.iaok, o.daok}); end
    endtask

    initial begin
        reset       = 1'b1;
        inst_req    = 1'b0;
        inst_size   = 2'd2;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        test_reset();
        test_inst_read();
        test_simultaneous();
        test_starvation();
        test_backpressure();
        test_reset_mid_op();
        test_store_routing();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the core's single SRAM-like memory bus between instruction fetch (inst port) and the EX/MEM data access (data port).
- Sits between the pipeline's fetch/EX stages and the external bus (cache or AXI bridge).
- Uses a req/addr_ok/data_ok handshake with one outstanding transaction at a time.
- Data has fixed priority over inst, with an anti-starvation counter.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive inst losses after which inst wins the next arbitration.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request (read only)
- inst_size  in  2  access size (0=byte, 1=half, 2=word)
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  inst request accepted
- inst_data_ok  out  1  inst read data valid
- inst_rdata  out  DATA_W  inst read data
- data_req  in  1  data request
- data_wr  in  1  1=store, 0=load
- data_size  in  2  access size
- data_wstrb  in  DATA_W/8  byte enables for store
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data valid / store complete
- data_rdata  out  DATA_W  load data
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_size  out  2  bus size
- bus_wstrb  out  DATA_W/8  bus byte enables
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_addr_ok  in  1  bus accepted request
- bus_data_ok  in  1  bus response
- bus_rdata  in  DATA_W  bus read data

Behaviour:
- FSM states: IDLE, ADDR, DATA. Registers: owner (0=inst, 1=data), starve_cnt (3 bits, saturating at STARVE_LIMIT).
- Reset: state=IDLE, owner=0, starve_cnt=0. bus_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are all 0 while state=IDLE.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise latch the winner into owner and go to ADDR next cycle.
  - Winner is data if data_req and not (inst_req and starve_cnt==STARVE_LIMIT); otherwise inst.
- starve_cnt, updated on the IDLE grant edge only:
  - data granted while inst_req=1: increment, saturating.
  - inst granted: clear to 0.
  - otherwise: hold.
- ADDR:
  - bus_req=1.
  - bus_wr, bus_size, bus_wstrb, bus_addr and bus_wdata are muxed combinationally from the owner's port.
  - For the inst owner: bus_wr=0, bus_wstrb=0, bus_wdata=0.
  - Owner's addr_ok = bus_addr_ok, combinational. The non-owner's addr_ok is 0.
  - On bus_addr_ok go to DATA.
- DATA:
  - bus_req=0.
  - Owner's data_ok = bus_data_ok, combinational. The non-owner's data_ok is 0.
  - On bus_data_ok go to IDLE.
- inst_rdata and data_rdata both equal bus_rdata combinationally. They are only meaningful with the matching data_ok.
- bus_data_ok in IDLE or ADDR (stale response after reset) is ignored and never forwarded.
- Latency:
  - Request to bus_req: 1 cycle (grant registered).
  - Back-to-back transactions: minimum 3 cycles each (IDLE, ADDR, DATA with single-cycle slave).
- Masters hold req and payload stable until their addr_ok. The arbiter does not re-arbitrate once in ADDR, even if a higher-priority req arrives.
- A new req arriving in the same cycle as bus_data_ok is arbitrated in the following IDLE cycle.
- Reset mid-transaction: next state is IDLE, bus_req=0, and the pending response is dropped.

Test Plan:
- Single inst read: inst_req=1, inst_addr=0x1c000000, slave addr_ok on 1st ADDR cycle, data_ok 2 cycles later with rdata=0x02800c0c.
  -> bus_req high 1 cycle after inst_req; inst_data_ok pulses once with inst_rdata=0x02800c0c; data_* outputs stay 0.
- Simultaneous requests: inst_req=1 and data_req=1 (store, addr 0x1c008000, wstrb=0xF, wdata=0xdeadbeef) in the same cycle.
  -> data served first with bus_wr=1 and bus_wdata=0xdeadbeef; inst served immediately after; starve_cnt=0 at end.
- Starvation: inst_req held high while data_req re-asserts every IDLE cycle.
  -> data wins 4 grants, inst wins the 5th, starve_cnt returns to 0; pattern repeats.
- Addr_ok backpressure: slave holds bus_addr_ok=0 for 5 cycles during a data load.
  -> bus_req and bus_addr stay constant for 5 cycles; a late inst_req is not granted until data_data_ok.
- Reset mid-op: assert reset in DATA state, then bus_data_ok arrives the cycle after reset drops.
  -> state IDLE, no data_ok forwarded, bus_req=0.
- Store response routing: data store completes with bus_data_ok=1 and bus_rdata=0x12345678.
  -> data_data_ok=1, inst_data_ok=0; next inst fetch gets addr_ok only in its own ADDR phase.
